// File: rtl/fifo_param_pkg.sv
// Shared defaults for the parametrised FIFO: default geometry and the count-width rule.
// The FIFO_ERR_STICKY_EN macro selects a sticky error flag instead of the one-cycle pulse.
package fifo_param_pkg;

  localparam int DEF_WORD_SIZE = 6;
  localparam int DEF_MEM_SIZE  = 8;

  // Occupancy must represent 0..MEM_SIZE inclusive, hence one bit wider than a pointer.
  function automatic int cnt_width(input int mem_size);
    return $clog2(mem_size) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// MEM_SIZE x WORD_SIZE dual-port RAM: synchronous write, registered synchronous read.
// The read register clears on reset and holds its value when no read is issued.
module fifo_mem
  import fifo_param_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int PTR_L     = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 wr_en,
  input  logic [PTR_L-1:0]     wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [PTR_L-1:0]     rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read and write to the same address on one edge returns the old word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, read-valid strobe and threshold flags.
// Define FIFO_ERR_STICKY_EN to make the overflow/underflow error flag sticky until reset.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int PTR_L     = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic [PTR_L:0]       full_threshold,
  input  logic [PTR_L:0]       empty_threshold,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_valid,
  output logic [PTR_L:0]       fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  localparam int CNT_W = PTR_L + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_SIZE);

  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok;
  logic             rd_ok;
  logic             overflow;
  logic             underflow;

  // Handshake: a write is taken when fifo_wr is high and there is room or a read frees a slot
  // on the same edge; a read is taken when fifo_rd is high and the FIFO is not empty. Taken
  // reads present their word on fifo_data_out with fifo_valid high one cycle later.
  always_comb begin
    wr_ok     = fifo_wr & (~fifo_full | fifo_rd);
    rd_ok     = fifo_rd & ~fifo_empty;
    overflow  = fifo_wr & fifo_full & ~fifo_rd;
    underflow = fifo_rd & fifo_empty;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_valid <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      fifo_valid <= rd_ok;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error <= 1'b0;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      error <= error | overflow | underflow;
`else
      error <= overflow | underflow;
`endif
    end
  end

  // Flags decode the registered count so they move on the same edge as fifo_count.
  always_comb begin
    fifo_count   = count;
    fifo_full    = (count == FULL_CNT);
    fifo_empty   = (count == '0);
    almost_full  = (count >= full_threshold);
    almost_empty = (count <= empty_threshold);
  end

  fifo_mem #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE),
    .PTR_L     (PTR_L)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (fifo_data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (fifo_data_out)
  );

endmodule
